// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS debug sequencer.
// The optional cycle counter (DBG_CYCLE_CNT_EN) adds a PH_CNT word after the PC.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DUMP_PC,
        ST_DUMP_REG,
        ST_DUMP_MEM,
        ST_SEND
    } dbg_state_t;

    typedef enum logic [1:0] {
        PH_PC,
        PH_CNT,
        PH_REG,
        PH_MEM
    } dump_phase_t;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_HALT = 8'h68;

    localparam int WORD_BYTES = 4;
    localparam int NUM_REGS   = 32;

endpackage

// File: rtl/dbg_word_serializer.sv
// Loads one datapath word and emits it MSB-first as WORD_BYTES bytes over valid/ready.
// done pulses for one cycle after the last byte is accepted.
module dbg_word_serializer
    import mips_dbg_pkg::*;
#(
    parameter int MSB = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [MSB:0] word,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    output logic         done
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [MSB:0] shift_q;
    logic [1:0]   byte_cnt;

    assign tx_data = shift_q[MSB -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shift_q  <= word;
                byte_cnt <= '0;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                shift_q  <= shift_q << 8;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == LAST_BYTE) begin
                    tx_valid <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Debug sequencer for the 5-stage MIPS core: run/step/halt via UART commands, then
// dumps PC, GPRs and data memory as a byte stream. Optional macro: DBG_CYCLE_CNT_EN.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_IDLE      | waiting for 'c' or 's'
//  ST_RUN       | core enabled until pc_end or 'h'
//  ST_STEP      | one-cycle enable pulse (skipped when pc_end), then dump
//  ST_DUMP_PC   | capture PC (or cycle counter) into the serializer
//  ST_DUMP_REG  | register address settles one cycle, then capture
//  ST_DUMP_MEM  | memory address settles one cycle, then capture
//  ST_SEND      | serializer busy; advance index/phase when it finishes
module mips_debug_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int MSB       = 31,
    parameter int MEM_WORDS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         mdb_ena,
    output logic [4:0]   du_areg,
    output logic         du_c1,
    output logic [MSB:0] du_amem,
    output logic         du_c2,
    input  logic [MSB:0] pc_in,
    input  logic         pc_end,
    input  logic [MSB:0] reg_data,
    input  logic [MSB:0] mem_data,
    output logic         busy
);

`ifdef DBG_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_REG = 8'(NUM_REGS - 1);
    localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);

    dbg_state_t   state;
    dump_phase_t  phase;
    logic [7:0]   idx;
    logic [7:0]   idx_next;
    logic         rd_wait;
    logic         step_fired;
    logic         ser_load;
    logic [MSB:0] ser_word;
    logic         ser_done;

    assign idx_next = idx + 8'd1;

`ifdef DBG_CYCLE_CNT_EN
    logic [MSB:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cyc_cnt <= '0;
        else if (mdb_ena)
            cyc_cnt <= cyc_cnt + 1'b1;
    end
`endif

    // Capture strobe and data source for the serializer's shift register.
    always_comb begin
        ser_load = 1'b0;
        ser_word = pc_in;
        case (state)
            ST_DUMP_PC: begin
                ser_load = 1'b1;
`ifdef DBG_CYCLE_CNT_EN
                if (phase == PH_CNT)
                    ser_word = cyc_cnt;
`endif
            end
            ST_DUMP_REG: begin
                ser_load = !rd_wait;
                ser_word = reg_data;
            end
            ST_DUMP_MEM: begin
                ser_load = !rd_wait;
                ser_word = mem_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase      <= PH_PC;
            idx        <= '0;
            rd_wait    <= 1'b0;
            step_fired <= 1'b0;
            mdb_ena    <= 1'b0;
            du_areg    <= '0;
            du_c1      <= 1'b0;
            du_amem    <= '0;
            du_c2      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mdb_ena <= 1'b0;
                    if (rx_valid && rx_data == CMD_RUN) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else if (rx_valid && rx_data == CMD_STEP) begin
                        state      <= ST_STEP;
                        step_fired <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pc_end || (rx_valid && rx_data == CMD_HALT)) begin
                        mdb_ena <= 1'b0;
                        phase   <= PH_PC;
                        state   <= ST_DUMP_PC;
                    end else begin
                        mdb_ena <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (!step_fired) begin
                        mdb_ena    <= !pc_end;
                        step_fired <= 1'b1;
                    end else begin
                        mdb_ena <= 1'b0;
                        phase   <= PH_PC;
                        state   <= ST_DUMP_PC;
                    end
                end
                ST_DUMP_PC: state <= ST_SEND;
                ST_DUMP_REG, ST_DUMP_MEM: begin
                    if (rd_wait)
                        rd_wait <= 1'b0;
                    else
                        state <= ST_SEND;
                end
                ST_SEND: begin
                    if (ser_done) begin
                        case (phase)
                            PH_PC, PH_CNT: begin
                                if (phase == PH_PC && CNT_EN) begin
                                    phase <= PH_CNT;
                                    state <= ST_DUMP_PC;
                                end else begin
                                    phase   <= PH_REG;
                                    idx     <= '0;
                                    du_c1   <= 1'b1;
                                    du_areg <= '0;
                                    rd_wait <= 1'b1;
                                    state   <= ST_DUMP_REG;
                                end
                            end
                            PH_REG: begin
                                if (idx == LAST_REG) begin
                                    du_c1   <= 1'b0;
                                    phase   <= PH_MEM;
                                    idx     <= '0;
                                    du_c2   <= 1'b1;
                                    du_amem <= '0;
                                    rd_wait <= 1'b1;
                                    state   <= ST_DUMP_MEM;
                                end else begin
                                    idx     <= idx_next;
                                    du_areg <= 5'(idx_next);
                                    rd_wait <= 1'b1;
                                    state   <= ST_DUMP_REG;
                                end
                            end
                            PH_MEM: begin
                                if (idx == LAST_MEM) begin
                                    du_c2 <= 1'b0;
                                    idx   <= '0;
                                    phase <= PH_PC;
                                    busy  <= 1'b0;
                                    state <= ST_IDLE;
                                end else begin
                                    idx     <= idx_next;
                                    du_amem <= (MSB+1)'({idx_next, 2'b00});
                                    rd_wait <= 1'b1;
                                    state   <= ST_DUMP_MEM;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dbg_word_serializer #(
        .MSB (MSB)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .word     (ser_word),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (ser_done)
    );

endmodule
